// File: rtl/mem_arbiter.sv
// Two-source arbiter sharing one data-memory port between instruction fetch and load/store.
// One transaction in flight; round-robin on contention; registered request channel to the bus.
module mem_arbiter #(
    parameter int XLEN   = 32,
    parameter int STRB_W = XLEN / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ifu_req_valid_i,
    output logic              ifu_req_ready_o,
    input  logic [XLEN-1:0]   ifu_req_addr_i,
    output logic              ifu_rsp_valid_o,
    input  logic              ifu_rsp_ready_i,
    output logic [XLEN-1:0]   ifu_rsp_rdata_o,
    input  logic              lsu_req_valid_i,
    output logic              lsu_req_ready_o,
    input  logic [XLEN-1:0]   lsu_req_addr_i,
    input  logic              lsu_req_wen_i,
    input  logic [XLEN-1:0]   lsu_req_wdata_i,
    input  logic [STRB_W-1:0] lsu_req_wstrb_i,
    output logic              lsu_rsp_valid_o,
    input  logic              lsu_rsp_ready_i,
    output logic [XLEN-1:0]   lsu_rsp_rdata_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [XLEN-1:0]   mem_req_addr_o,
    output logic              mem_req_wen_o,
    output logic [XLEN-1:0]   mem_req_wdata_o,
    output logic [STRB_W-1:0] mem_req_wstrb_o,
    input  logic              mem_rsp_valid_i,
    output logic              mem_rsp_ready_o,
    input  logic [XLEN-1:0]   mem_rsp_rdata_i,
    output logic              busy_o,
    output logic              owner_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_owner;
    logic                r_busy;
    logic                r_req_valid;
    logic [XLEN-1:0]     r_addr;
    logic                r_wen;
    logic [XLEN-1:0]     r_wdata;
    logic [STRB_W-1:0]   r_wstrb;

    logic                w_grant_ifu;
    logic                w_grant_lsu;
    logic                w_in_resp;
    logic                w_rsp_ready;

    // Winner selection in IDLE: lone requester wins, contention goes to the non-owner.
    always_comb begin
        w_grant_ifu = 1'b0;
        w_grant_lsu = 1'b0;
        if (r_state == ST_IDLE) begin
            if (ifu_req_valid_i && lsu_req_valid_i) begin
                if (r_owner) begin
                    w_grant_ifu = 1'b1;
                end else begin
                    w_grant_lsu = 1'b1;
                end
            end else if (ifu_req_valid_i) begin
                w_grant_ifu = 1'b1;
            end else if (lsu_req_valid_i) begin
                w_grant_lsu = 1'b1;
            end else begin
                w_grant_ifu = 1'b0;
            end
        end else begin
            w_grant_ifu = 1'b0;
        end
    end

    // Response routing to the current owner; the other side sees nothing.
    always_comb begin
        w_in_resp       = (r_state == ST_RESP);
        w_rsp_ready     = 1'b0;
        ifu_rsp_valid_o = 1'b0;
        lsu_rsp_valid_o = 1'b0;
        ifu_rsp_rdata_o = {XLEN{1'b0}};
        lsu_rsp_rdata_o = {XLEN{1'b0}};
        if (w_in_resp) begin
            if (r_owner) begin
                w_rsp_ready     = lsu_rsp_ready_i;
                lsu_rsp_valid_o = mem_rsp_valid_i;
                lsu_rsp_rdata_o = mem_rsp_rdata_i;
            end else begin
                w_rsp_ready     = ifu_rsp_ready_i;
                ifu_rsp_valid_o = mem_rsp_valid_i;
                ifu_rsp_rdata_o = mem_rsp_rdata_i;
            end
        end else begin
            w_rsp_ready = 1'b0;
        end
    end

    assign ifu_req_ready_o = w_grant_ifu;
    assign lsu_req_ready_o = w_grant_lsu;
    assign mem_rsp_ready_o = w_rsp_ready;
    assign mem_req_valid_o = r_req_valid;
    assign mem_req_addr_o  = r_addr;
    assign mem_req_wen_o   = r_wen;
    assign mem_req_wdata_o = r_wdata;
    assign mem_req_wstrb_o = r_wstrb;
    assign busy_o          = r_busy;
    assign owner_o         = r_owner;

    // Transaction FSM; owner resets to LSU so the first contention favours fetch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_owner     <= 1'b1;
            r_busy      <= 1'b0;
            r_req_valid <= 1'b0;
            r_addr      <= {XLEN{1'b0}};
            r_wen       <= 1'b0;
            r_wdata     <= {XLEN{1'b0}};
            r_wstrb     <= {STRB_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_ifu) begin
                        r_addr      <= ifu_req_addr_i;
                        r_wen       <= 1'b0;
                        r_wdata     <= {XLEN{1'b0}};
                        r_wstrb     <= {STRB_W{1'b0}};
                        r_owner     <= 1'b0;
                        r_req_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_REQ;
                    end else if (w_grant_lsu) begin
                        r_addr      <= lsu_req_addr_i;
                        r_wen       <= lsu_req_wen_i;
                        r_wdata     <= lsu_req_wdata_i;
                        r_wstrb     <= lsu_req_wstrb_i;
                        r_owner     <= 1'b1;
                        r_req_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready_i) begin
                        r_req_valid <= 1'b0;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (mem_rsp_valid_i && w_rsp_ready) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_req_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, store, round-robin, request/response stalls, mid-flight reset.
module tb_mem_arbiter;

    localparam int XLEN   = 32;
    localparam int STRB_W = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              ifu_req_valid_i, ifu_req_ready_o;
    logic [XLEN-1:0]   ifu_req_addr_i;
    logic              ifu_rsp_valid_o, ifu_rsp_ready_i;
    logic [XLEN-1:0]   ifu_rsp_rdata_o;
    logic              lsu_req_valid_i, lsu_req_ready_o;
    logic [XLEN-1:0]   lsu_req_addr_i;
    logic              lsu_req_wen_i;
    logic [XLEN-1:0]   lsu_req_wdata_i;
    logic [STRB_W-1:0] lsu_req_wstrb_i;
    logic              lsu_rsp_valid_o, lsu_rsp_ready_i;
    logic [XLEN-1:0]   lsu_rsp_rdata_o;
    logic              mem_req_valid_o, mem_req_ready_i;
    logic [XLEN-1:0]   mem_req_addr_o;
    logic              mem_req_wen_o;
    logic [XLEN-1:0]   mem_req_wdata_o;
    logic [STRB_W-1:0] mem_req_wstrb_o;
    logic              mem_rsp_valid_i, mem_rsp_ready_o;
    logic [XLEN-1:0]   mem_rsp_rdata_i;
    logic              busy_o, owner_o;

    int n_vec  = 0;
    int n_miss = 0;

    mem_arbiter #(.XLEN(XLEN), .STRB_W(STRB_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ifu_req_valid_i(ifu_req_valid_i), .ifu_req_ready_o(ifu_req_ready_o),
        .ifu_req_addr_i(ifu_req_addr_i),
        .ifu_rsp_valid_o(ifu_rsp_valid_o), .ifu_rsp_ready_i(ifu_rsp_ready_i),
        .ifu_rsp_rdata_o(ifu_rsp_rdata_o),
        .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o),
        .lsu_req_addr_i(lsu_req_addr_i), .lsu_req_wen_i(lsu_req_wen_i),
        .lsu_req_wdata_i(lsu_req_wdata_i), .lsu_req_wstrb_i(lsu_req_wstrb_i),
        .lsu_rsp_valid_o(lsu_rsp_valid_o), .lsu_rsp_ready_i(lsu_rsp_ready_i),
        .lsu_rsp_rdata_o(lsu_rsp_rdata_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_wen_o(mem_req_wen_o),
        .mem_req_wdata_o(mem_req_wdata_o), .mem_req_wstrb_o(mem_req_wstrb_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
        .mem_rsp_rdata_i(mem_rsp_rdata_i),
        .busy_o(busy_o), .owner_o(owner_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock; inputs change and outputs are sampled 1-2 time units after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        ifu_req_valid_i = 1'b0; ifu_req_addr_i = 32'h0; ifu_rsp_ready_i = 1'b0;
        lsu_req_valid_i = 1'b0; lsu_req_addr_i = 32'h0; lsu_req_wen_i = 1'b0;
        lsu_req_wdata_i = 32'h0; lsu_req_wstrb_i = 4'h0; lsu_rsp_ready_i = 1'b0;
        mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_rdata_i = 32'h0;
        do_reset();
        n_vec++; if (mem_req_valid_o !== 1'b0) begin n_miss++; $display("FAIL reset_mem_valid got %b exp 0", mem_req_valid_o); end
        n_vec++; if (owner_o !== 1'b1) begin n_miss++; $display("FAIL reset_owner got %b exp 1", owner_o); end
        n_vec++; if (busy_o !== 1'b0) begin n_miss++; $display("FAIL reset_busy got %b exp 0", busy_o); end
        n_vec++; if ({mem_req_addr_o, mem_req_wdata_o, mem_req_wstrb_o, mem_req_wen_o} !== 69'h0) begin n_miss++; $display("FAIL reset_payload got %h/%h/%h/%b exp 0", mem_req_addr_o, mem_req_wdata_o, mem_req_wstrb_o, mem_req_wen_o); end
        n_vec++; if ({ifu_req_ready_o, lsu_req_ready_o, ifu_rsp_valid_o, lsu_rsp_valid_o, mem_rsp_ready_o} !== 5'b0) begin n_miss++; $display("FAIL reset_handshakes got %b exp 00000", {ifu_req_ready_o, lsu_req_ready_o, ifu_rsp_valid_o, lsu_rsp_valid_o, mem_rsp_ready_o}); end
    endtask

    task automatic test_ifu_fetch();
        ifu_req_valid_i = 1'b1; ifu_req_addr_i = 32'h8000_0000;
        #1;
        n_vec++; if ({ifu_req_ready_o, lsu_req_ready_o} !== 2'b10) begin n_miss++; $display("FAIL fetch_grant got %b exp 10", {ifu_req_ready_o, lsu_req_ready_o}); end
        tick();
        ifu_req_valid_i = 1'b0; ifu_req_addr_i = 32'h0;
        n_vec++; if (mem_req_valid_o !== 1'b1) begin n_miss++; $display("FAIL fetch_req_valid got %b exp 1", mem_req_valid_o); end
        n_vec++; if (mem_req_addr_o !== 32'h8000_0000) begin n_miss++; $display("FAIL fetch_addr got %h exp 80000000", mem_req_addr_o); end
        n_vec++; if ({mem_req_wstrb_o, mem_req_wen_o} !== 5'b0) begin n_miss++; $display("FAIL fetch_wstrb_wen got %h/%b exp 0/0", mem_req_wstrb_o, mem_req_wen_o); end
        n_vec++; if ({owner_o, busy_o} !== 2'b01) begin n_miss++; $display("FAIL fetch_owner_busy got %b exp 01", {owner_o, busy_o}); end
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b1; mem_rsp_rdata_i = 32'h0010_0073; ifu_rsp_ready_i = 1'b1;
        #1;
        n_vec++; if (mem_req_valid_o !== 1'b0) begin n_miss++; $display("FAIL fetch_req_drop got %b exp 0", mem_req_valid_o); end
        n_vec++; if (ifu_rsp_valid_o !== 1'b1 || ifu_rsp_rdata_o !== 32'h0010_0073) begin n_miss++; $display("FAIL fetch_rsp got %b/%h exp 1/00100073", ifu_rsp_valid_o, ifu_rsp_rdata_o); end
        n_vec++; if ({lsu_rsp_valid_o, mem_rsp_ready_o} !== 2'b01) begin n_miss++; $display("FAIL fetch_lsu_quiet got %b exp 01", {lsu_rsp_valid_o, mem_rsp_ready_o}); end
        tick();
        n_vec++; if ({busy_o, ifu_rsp_valid_o, mem_rsp_ready_o} !== 3'b000) begin n_miss++; $display("FAIL fetch_done got %b exp 000", {busy_o, ifu_rsp_valid_o, mem_rsp_ready_o}); end
        mem_rsp_valid_i = 1'b0; ifu_rsp_ready_i = 1'b0;
    endtask

    task automatic test_lsu_store();
        int pulses;
        lsu_req_valid_i = 1'b1; lsu_req_addr_i = 32'h8000_1000; lsu_req_wen_i = 1'b1;
        lsu_req_wdata_i = 32'hDEAD_BEEF; lsu_req_wstrb_i = 4'hF;
        #1;
        n_vec++; if ({ifu_req_ready_o, lsu_req_ready_o} !== 2'b01) begin n_miss++; $display("FAIL store_grant got %b exp 01", {ifu_req_ready_o, lsu_req_ready_o}); end
        tick();
        lsu_req_valid_i = 1'b0; lsu_req_wdata_i = 32'h0; lsu_req_wstrb_i = 4'h0; lsu_req_wen_i = 1'b0;
        n_vec++; if ({mem_req_valid_o, mem_req_wen_o} !== 2'b11) begin n_miss++; $display("FAIL store_valid_wen got %b exp 11", {mem_req_valid_o, mem_req_wen_o}); end
        n_vec++; if (mem_req_addr_o !== 32'h8000_1000 || mem_req_wdata_o !== 32'hDEAD_BEEF || mem_req_wstrb_o !== 4'hF) begin n_miss++; $display("FAIL store_payload got %h/%h/%h exp 80001000/deadbeef/f", mem_req_addr_o, mem_req_wdata_o, mem_req_wstrb_o); end
        n_vec++; if (owner_o !== 1'b1) begin n_miss++; $display("FAIL store_owner got %b exp 1", owner_o); end
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b1; mem_rsp_rdata_i = 32'h0; lsu_rsp_ready_i = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (lsu_rsp_valid_o === 1'b1) pulses++;
            tick();
            mem_rsp_valid_i = 1'b0;
        end
        lsu_rsp_ready_i = 1'b0;
        n_vec++; if (pulses !== 1) begin n_miss++; $display("FAIL store_rsp_pulses got %0d exp 1", pulses); end
        n_vec++; if (busy_o !== 1'b0) begin n_miss++; $display("FAIL store_idle got %b exp 0", busy_o); end
    endtask

    task automatic test_round_robin();
        do_reset();
        ifu_req_valid_i = 1'b1; ifu_req_addr_i = 32'h0000_0100;
        lsu_req_valid_i = 1'b1; lsu_req_addr_i = 32'h0000_0200; lsu_req_wen_i = 1'b0;
        ifu_rsp_ready_i = 1'b1; lsu_rsp_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic exp_lsu;
            exp_lsu = (k % 2 == 1);
            #1;
            n_vec++; if ({ifu_req_ready_o, lsu_req_ready_o} !== {~exp_lsu, exp_lsu}) begin n_miss++; $display("FAIL rr_grant%0d got %b exp %b", k, {ifu_req_ready_o, lsu_req_ready_o}, {~exp_lsu, exp_lsu}); end
            tick();
            n_vec++; if (owner_o !== exp_lsu || mem_req_addr_o !== (exp_lsu ? 32'h200 : 32'h100)) begin n_miss++; $display("FAIL rr_owner%0d got %b/%h exp %b", k, owner_o, mem_req_addr_o, exp_lsu); end
            mem_req_ready_i = 1'b1;
            tick();
            mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b1;
            #1;
            n_vec++; if ({ifu_req_ready_o, lsu_req_ready_o} !== 2'b00) begin n_miss++; $display("FAIL rr_resp_nogrant%0d got %b exp 00", k, {ifu_req_ready_o, lsu_req_ready_o}); end
            tick();
            mem_rsp_valid_i = 1'b0;
        end
        ifu_req_valid_i = 1'b0; lsu_req_valid_i = 1'b0;
        ifu_rsp_ready_i = 1'b0; lsu_rsp_ready_i = 1'b0;
        tick();
    endtask

    task automatic test_stalls();
        lsu_req_valid_i = 1'b1; lsu_req_addr_i = 32'h0000_1234; lsu_req_wen_i = 1'b0;
        lsu_req_wdata_i = 32'h0; lsu_req_wstrb_i = 4'h0;
        tick();
        lsu_req_valid_i = 1'b0; lsu_req_addr_i = 32'hFFFF_FFFF; ifu_req_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_vec++; if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'h0000_1234 || mem_req_wen_o !== 1'b0) begin n_miss++; $display("FAIL stall_req%0d got %b/%h exp 1/00001234", i, mem_req_valid_o, mem_req_addr_o); end
            n_vec++; if ({ifu_req_ready_o, lsu_req_ready_o} !== 2'b00) begin n_miss++; $display("FAIL stall_ready%0d got %b exp 00", i, {ifu_req_ready_o, lsu_req_ready_o}); end
            tick();
        end
        ifu_req_valid_i = 1'b0;
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b1; mem_rsp_rdata_i = 32'hCAFE_F00D;
        lsu_rsp_ready_i = 1'b0; ifu_rsp_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if ({mem_rsp_ready_o, busy_o, lsu_rsp_valid_o} !== 3'b011) begin n_miss++; $display("FAIL rsp_stall%0d got %b exp 011", i, {mem_rsp_ready_o, busy_o, lsu_rsp_valid_o}); end
            tick();
        end
        lsu_rsp_ready_i = 1'b1;
        #1;
        n_vec++; if (mem_rsp_ready_o !== 1'b1 || lsu_rsp_rdata_o !== 32'hCAFE_F00D || ifu_rsp_valid_o !== 1'b0) begin n_miss++; $display("FAIL rsp_release got %b/%h/%b exp 1/cafef00d/0", mem_rsp_ready_o, lsu_rsp_rdata_o, ifu_rsp_valid_o); end
        tick();
        mem_rsp_valid_i = 1'b0; lsu_rsp_ready_i = 1'b0; ifu_rsp_ready_i = 1'b0;
        n_vec++; if (busy_o !== 1'b0) begin n_miss++; $display("FAIL rsp_complete got %b exp 0", busy_o); end
    endtask

    task automatic test_reset_mid();
        ifu_req_valid_i = 1'b1; ifu_req_addr_i = 32'h0000_0040;
        tick();
        ifu_req_valid_i = 1'b0;
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b1; ifu_rsp_ready_i = 1'b0;
        #1;
        n_vec++; if ({busy_o, owner_o, ifu_rsp_valid_o} !== 3'b101) begin n_miss++; $display("FAIL mid_in_resp got %b exp 101", {busy_o, owner_o, ifu_rsp_valid_o}); end
        rst_i = 1'b1;
        #1;
        n_vec++; if ({ifu_rsp_valid_o, lsu_rsp_valid_o, mem_req_valid_o, mem_rsp_ready_o, busy_o, owner_o} !== 6'b000001) begin n_miss++; $display("FAIL mid_reset got %b exp 000001", {ifu_rsp_valid_o, lsu_rsp_valid_o, mem_req_valid_o, mem_rsp_ready_o, busy_o, owner_o}); end
        n_vec++; if (mem_req_addr_o !== 32'h0) begin n_miss++; $display("FAIL mid_reset_addr got %h exp 0", mem_req_addr_o); end
        tick();
        rst_i = 1'b0; ifu_rsp_ready_i = 1'b1; lsu_rsp_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_vec++; if ({ifu_rsp_valid_o, lsu_rsp_valid_o, mem_rsp_ready_o, busy_o} !== 4'b0000) begin n_miss++; $display("FAIL stray_rsp%0d got %b exp 0000", i, {ifu_rsp_valid_o, lsu_rsp_valid_o, mem_rsp_ready_o, busy_o}); end
            tick();
        end
        mem_rsp_valid_i = 1'b0; ifu_rsp_ready_i = 1'b0; lsu_rsp_ready_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ifu_fetch();
        test_lsu_store();
        test_round_robin();
        test_stalls();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
